// File: rtl/chan_scan_seq_if.sv
// rtl/chan_scan_seq_if.sv - control/status bundle between scan sequencer and its host
interface chan_scan_seq_if #(
  parameter int IDX_W = 7,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             cont;
  logic [IDX_W-1:0] first_ch;
  logic [IDX_W-1:0] last_ch;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] gap;
  logic [IDX_W-1:0] ch_idx;
  logic             ch_valid;
  logic             sample_stb;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output start, abort, cont, first_ch, last_ch, dwell, gap,
    input  ch_idx, ch_valid, sample_stb, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cont, first_ch, last_ch, dwell, gap,
    output ch_idx, ch_valid, sample_stb, busy, done, cfg_err
  );
endinterface

// File: rtl/chan_scan_seq.sv
// rtl/chan_scan_seq.sv - channel scan sequencer feeding the one-hot channel decoder
module chan_scan_seq #(
  parameter int NCH       = 80,
  parameter int IDX_W     = 7,
  parameter int CNT_W     = 16,
  parameter int BLANK_IDX = 127
) (
  input  logic            clk,
  input  logic            rst,
  chan_scan_seq_if.slave  bus
);
  localparam logic [IDX_W-1:0] BLANK = IDX_W'(BLANK_IDX);

  typedef enum logic [1:0] {IDLE, GAP, DWELL} state_t;

  state_t           state;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] first_r;
  logic [IDX_W-1:0] last_r;
  logic [CNT_W-1:0] dwell_r;
  logic [CNT_W-1:0] gap_r;
  logic             cont_r;
  logic [CNT_W-1:0] cnt;  // cycles remaining in the current GAP/DWELL segment, minus one

  logic [IDX_W-1:0] next_cur;
  logic             bad_cfg;

  assign next_cur = (cur == last_r) ? first_r : cur + IDX_W'(1);
  assign bad_cfg  = (bus.first_ch > bus.last_ch) || (bus.last_ch >= IDX_W'(NCH)) ||
                    (bus.dwell == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cur            <= '0;
      first_r        <= '0;
      last_r         <= '0;
      dwell_r        <= '0;
      gap_r          <= '0;
      cont_r         <= 1'b0;
      cnt            <= '0;
      bus.ch_idx     <= BLANK;
      bus.ch_valid   <= 1'b0;
      bus.sample_stb <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cfg_err    <= 1'b0;
    end else begin
      bus.sample_stb <= 1'b0;
      bus.done       <= 1'b0;
      bus.cfg_err    <= 1'b0;
      if (bus.abort) begin
        state        <= IDLE;
        bus.ch_idx   <= BLANK;
        bus.ch_valid <= 1'b0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bad_cfg) begin
                bus.cfg_err <= 1'b1;
              end else begin
                first_r  <= bus.first_ch;
                last_r   <= bus.last_ch;
                dwell_r  <= bus.dwell;
                gap_r    <= bus.gap;
                cont_r   <= bus.cont;
                cur      <= bus.first_ch;
                bus.busy <= 1'b1;
                if (bus.gap != '0) begin
                  state <= GAP;
                  cnt   <= bus.gap - CNT_W'(1);
                end else begin
                  state          <= DWELL;
                  cnt            <= bus.dwell - CNT_W'(1);
                  bus.ch_idx     <= bus.first_ch;
                  bus.ch_valid   <= 1'b1;
                  bus.sample_stb <= (bus.dwell == CNT_W'(1));
                end
              end
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state          <= DWELL;
              cnt            <= dwell_r - CNT_W'(1);
              bus.ch_idx     <= cur;
              bus.ch_valid   <= 1'b1;
              bus.sample_stb <= (dwell_r == CNT_W'(1));
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DWELL: begin
            if (cnt != '0) begin
              cnt            <= cnt - CNT_W'(1);
              bus.sample_stb <= (cnt == CNT_W'(1));
            end else if (cur == last_r && !cont_r) begin
              state        <= IDLE;
              bus.ch_idx   <= BLANK;
              bus.ch_valid <= 1'b0;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              cur <= next_cur;
              if (gap_r != '0) begin
                state        <= GAP;
                cnt          <= gap_r - CNT_W'(1);
                bus.ch_idx   <= BLANK;
                bus.ch_valid <= 1'b0;
              end else begin
                cnt            <= dwell_r - CNT_W'(1);
                bus.ch_idx     <= next_cur;
                bus.sample_stb <= (dwell_r == CNT_W'(1));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chan_scan_seq.sv
// tb/tb_chan_scan_seq.sv - randomized self-checking bench for chan_scan_seq
module tb_chan_scan_seq;
  localparam int NCH   = 80;
  localparam int BLANK = 127;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chan_scan_seq_if #(.IDX_W(7), .CNT_W(16)) bus ();
  chan_scan_seq #(.NCH(NCH), .IDX_W(7), .CNT_W(16), .BLANK_IDX(BLANK)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [11:0] tr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {cfg_err, busy, done, sample_stb, ch_valid, ch_idx[6:0]}
  function automatic logic [11:0] ev(input int idx, input bit v, input bit s, input bit b,
                                     input bit d, input bit e);
    return {e, b, d, s, v, 7'(idx)};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.cfg_err, bus.busy, bus.done, bus.sample_stb, bus.ch_valid, bus.ch_idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input int f, input int l, input int dw, input int gp, input bit c,
                       input int passes);
    tr.delete();
    for (int p = 0; p < passes; p++)
      for (int ch = f; ch <= l; ch++) begin
        for (int g = 0; g < gp; g++) tr.push_back(ev(BLANK, 0, 0, 1, 0, 0));
        for (int d = 0; d < dw; d++) tr.push_back(ev(ch, 1, d == dw - 1, 1, 0, 0));
      end
    if (!c) begin
      tr.push_back(ev(BLANK, 0, 0, 0, 1, 0));
      tr.push_back(ev(BLANK, 0, 0, 0, 0, 0));
    end
  endtask

  // stop_kind: 0 none, 1 abort, 2 reset, applied after checking trace cycle stop_at
  task automatic run(input string name, input int f, input int l, input int dw, input int gp,
                     input bit c, input int passes, input int stop_at, input int stop_kind,
                     input int exp_stb);
    int stb = 0;
    build(f, l, dw, gp, c, passes);
    bus.first_ch = 7'(f); bus.last_ch = 7'(l); bus.dwell = 16'(dw); bus.gap = 16'(gp);
    bus.cont = c; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      check($sformatf("%s/cyc%0d", name, i), 32'(obs()), 32'(tr[i]));
      check($sformatf("%s/inv%0d", name, i), 32'(bus.ch_valid), 32'(bus.ch_idx < NCH));
      stb += int'(bus.sample_stb);
      if (i == stop_at) begin
        bus.start = 1'b0;
        if (stop_kind == 1) bus.abort = 1'b1; else rst = 1'b1;
        tick();
        bus.abort = 1'b0; rst = 1'b0;
        check($sformatf("%s/stop", name), 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, 0)));
        tick();
        check($sformatf("%s/stop+1", name), 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, 0)));
        break;
      end
      // Config inputs and stray starts while busy must not disturb the scan.
      if (tr[i][10]) begin
        bus.start    = ($urandom % 3) == 0;
        bus.first_ch = 7'($urandom);
        bus.last_ch  = 7'($urandom);
        bus.dwell    = 16'($urandom);
        bus.gap      = 16'($urandom);
        bus.cont     = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    if (exp_stb >= 0) check($sformatf("%s/stb_count", name), 32'(stb), 32'(exp_stb));
  endtask

  task automatic cfg_case(input string name, input int f, input int l, input int dw,
                          input bit with_abort);
    bus.first_ch = 7'(f); bus.last_ch = 7'(l); bus.dwell = 16'(dw); bus.gap = 16'd1;
    bus.cont = 1'b0; bus.start = 1'b1; bus.abort = with_abort;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check({name, "/resp"}, 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, !with_abort && (f > l || l >= NCH || dw == 0))));
    tick();
    check({name, "/after"}, 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, 0)));
  endtask

  initial begin
    int f, l, dw, gp, passes;
    bit c;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
    bus.first_ch = '0; bus.last_ch = '0; bus.dwell = '0; bus.gap = '0;
    tick(); tick();
    check("reset", 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    tick();
    check("post_reset", 32'(obs()), 32'(ev(BLANK, 0, 0, 0, 0, 0)));

    run("single_0_2", 0, 2, 3, 1, 1'b0, 1, -1, 0, 3);
    run("edge_78_79", 78, 79, 1, 0, 1'b0, 1, -1, 0, 2);

    cfg_case("cfg_rev", 5, 4, 3, 1'b0);
    cfg_case("cfg_last80", 5, 80, 3, 1'b0);
    cfg_case("cfg_dwell0", 5, 6, 0, 1'b0);
    cfg_case("abort_bad", 5, 4, 3, 1'b1);
    cfg_case("abort_good", 1, 2, 3, 1'b1);

    run("cont_abort", 77, 79, 2, 0, 1'b1, 2, 3, 1, 2);
    run("single_ch_cont", 40, 40, 2, 1, 1'b1, 3, 8, 1, 3);
    run("rst_dwell", 10, 12, 4, 2, 1'b0, 1, 4, 2, -1);

    for (int k = 0; k < 25; k++) begin
      f  = $urandom_range(0, NCH - 1);
      l  = $urandom_range(f, (f + 4 > NCH - 1) ? NCH - 1 : f + 4);
      dw = $urandom_range(1, 5);
      gp = $urandom_range(0, 5);
      c  = 1'($urandom);
      passes = c ? 2 : 1;
      build(f, l, dw, gp, c, passes);
      run($sformatf("rand%0d", k), f, l, dw, gp, c, passes, c ? tr.size() - 1 : -1,
          c ? 1 : 0, passes * (l - f + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
